// File: rtl/piso_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_ctrl_pkg
// Brief   : Shared types and sizes for the PISO frame sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package piso_ctrl_pkg;

   localparam int PISO_WIDTH  = 20;
   localparam int BIT_CNT_W   = $clog2(PISO_WIDTH);
   localparam int FRAME_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : piso_bit_counter
// Brief   : Up-counter with clear, enable and terminal-count; saturates at
//           TERMINAL instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
module piso_bit_counter #(
   parameter int CNT_W    = 5,
   parameter int TERMINAL = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   logic [CNT_W-1:0] r_cnt;

   assign cnt = r_cnt;
   assign tc  = (r_cnt == CNT_W'(TERMINAL));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en && !tc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/piso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : piso_frame_ctrl
// Brief   : Loads one word into an external PISO and drains it LSB-first,
//           with frame qualifiers. Define PISO_CTRL_GAP_EN for idle gaps.
// Revision: 1.0 - initial release
// ============================================================================
module piso_frame_ctrl
   import piso_ctrl_pkg::*;
#(
   parameter int WIDTH      = PISO_WIDTH,
   parameter int GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       p_in,
   output logic                   capture,
   output logic                   shift,
   output logic                   frame_start,
   output logic                   bit_valid,
   output logic                   frame_done,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int c_BIT_CNT_W = $clog2(WIDTH);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [c_BIT_CNT_W-1:0]   w_bit_cnt;
   logic                     w_bit_last;
   logic                     w_accept;
   logic [WIDTH-1:0]         r_p_in;
   logic [FRAME_CNT_W-1:0]   r_frame_cnt;

   if (GAP_CYCLES < 0) begin : g_gap_cycles_check
      $error("GAP_CYCLES must be non-negative");
   end

   piso_bit_counter #(
      .CNT_W    (c_BIT_CNT_W),
      .TERMINAL (WIDTH - 1)
   ) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (r_state == ST_LOAD),
      .en  (r_state == ST_SHIFT),
      .cnt (w_bit_cnt),
      .tc  (w_bit_last)
   );

`ifdef PISO_CTRL_GAP_EN
   localparam int c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   logic [c_GAP_W-1:0] w_gap_cnt;
   logic               w_gap_last;

   // Held clear outside GAP so every gap starts counting from zero.
   piso_bit_counter #(
      .CNT_W    (c_GAP_W),
      .TERMINAL (c_GAP_LAST)
   ) u_gap_cnt (
      .clk (clk),
      .rst (rst),
      .clr (r_state != ST_GAP),
      .en  (r_state == ST_GAP),
      .cnt (w_gap_cnt),
      .tc  (w_gap_last)
   );
`endif

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      capture     = 1'b0;
      shift       = 1'b0;
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            capture     = 1'b1;
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift       = 1'b1;
            bit_valid   = 1'b1;
            frame_start = (w_bit_cnt == '0);
            if (w_bit_last) begin
               frame_done = 1'b1;
`ifdef PISO_CTRL_GAP_EN
               w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`else
               // Early accept overlaps the next word's handshake with the last bit.
               in_ready    = 1'b1;
               w_state_nxt = in_valid ? ST_LOAD : ST_IDLE;
`endif
            end
         end
`ifdef PISO_CTRL_GAP_EN
         ST_GAP: begin
            if (w_gap_last) w_state_nxt = ST_IDLE;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept  = in_valid && in_ready;
   assign busy      = (r_state != ST_IDLE);
   assign p_in      = r_p_in;
   assign frame_cnt = r_frame_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_p_in      <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_p_in <= in_data;
         if ((r_state == ST_SHIFT) && w_bit_last) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/piso_frame_ctrl.md
# piso_frame_ctrl

Sequencer for the 20-bit parallel-in/serial-out shift register. Accepts whole words from an upstream producer over a valid/ready handshake, drives the register's `capture`, `shift` and `p_in` inputs to load and drain one word LSB-first, and emits frame qualifiers so the downstream serial consumer knows which cycles carry valid bits. Sits between the word-level datapath and the PISO instance; the PISO itself is external.

## Interface
- `WIDTH`, 20, bits per frame; must match the PISO width.
- `GAP_CYCLES`, 2, idle cycles inserted after each frame; used only when `PISO_CTRL_GAP_EN` is defined.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  controller can accept a word.
- `p_in`  out  WIDTH  parallel word to PISO (held register).
- `capture`  out  1  PISO load strobe.
- `shift`  out  1  PISO shift-right enable.
- `frame_start`  out  1  PISO serial output carries bit 0 this cycle.
- `bit_valid`  out  1  PISO serial output carries a frame bit this cycle.
- `frame_done`  out  1  PISO serial output carries bit WIDTH-1 this cycle.
- `busy`  out  1  state is not IDLE.
- `frame_cnt`  out  8  completed frames, wraps 255 -> 0.

## Operation
- States: IDLE, LOAD, SHIFT, GAP. The GAP state exists only with the macro defined.
- IDLE: `in_ready`=1. On `in_valid && in_ready` at an edge, latch `in_data` into the hold register that drives `p_in`, then go to LOAD.
- LOAD: `capture`=1, `shift`=0, `in_ready`=0. Next state SHIFT, `bit_cnt`=0.
- SHIFT: `bit_valid`=1, `shift`=1, and `bit_cnt` increments each cycle.
  - `frame_start`=1 when `bit_cnt`==0.
  - On `bit_cnt`==WIDTH-1: `frame_done`=1, `frame_cnt` increments at that edge, and the block leaves SHIFT.
- GAP: all strobes 0, `in_ready`=0. Counts `GAP_CYCLES` cycles, then goes to IDLE.
- Outputs `capture`, `shift`, `in_ready`, `frame_start`, `bit_valid`, `frame_done` and `busy` are combinational decodes of state and `bit_cnt`. `p_in` and `frame_cnt` are registered.
- `p_in` is stable from LOAD through the end of SHIFT. It changes only on an accepted handshake.
- `in_data` is ignored while `in_ready`=0.
- `bit_cnt` is $clog2(WIDTH) bits wide and compares against WIDTH-1. It never wraps.

## Timing
- Reset values: state IDLE, `bit_cnt`=0, `p_in`=0, `frame_cnt`=0.
  - After reset: `in_ready`=1, `busy`=0, all strobes 0.
- `rst` asserted mid-frame aborts at the next edge: no `frame_done`, `frame_cnt` unchanged. The PISO contents are left stale, and the next LOAD overwrites them.
- `rst` takes priority over a simultaneous handshake; the word is dropped.
- Latency from the accept edge E0:
  - LOAD runs in the cycle after E0, and `capture` takes effect at E1.
  - Bit 0 is on the serial output in the cycle after E1 (`frame_start`=1).
  - Bit 19 appears 19 cycles later (`frame_done`=1).
- Without `PISO_CTRL_GAP_EN`: `in_ready`=1 also in the final SHIFT cycle (`bit_cnt`==WIDTH-1).
  - An accept there goes directly to LOAD, giving back-to-back frames at 21 cycles/word.
  - With no accept, the next state is IDLE (22 cycles/word minimum).
- `frame_done` and an early accept in the same cycle are legal. Both take effect, and `frame_cnt` increments.
- `frame_cnt` wraps 255 -> 0 without any flag.

## Configuration
- `PISO_CTRL_GAP_EN` defined: after SHIFT, enter GAP for `GAP_CYCLES` cycles, then IDLE.
  - No early accept in the last SHIFT cycle.
  - With `GAP_CYCLES`=0, go SHIFT -> IDLE directly, still with no early accept.
- Not defined: GAP state and gap counter are not compiled in, `GAP_CYCLES` is ignored, and early accept is enabled.

## Structure
- Package `piso_ctrl_pkg`:
  - state enum (IDLE, LOAD, SHIFT, GAP)
  - `PISO_WIDTH`=20
  - `BIT_CNT_W`=$clog2(PISO_WIDTH)
  - `FRAME_CNT_W`=8
- Sub-module `piso_bit_counter`: load-to-zero, enable, and terminal-count output. It is instantiated once for `bit_cnt` and, under the macro, once for the gap count.

## Test plan
- Reset then single word 20'h06850, held `in_valid` for one cycle:
  - `capture` high exactly 1 cycle after accept.
  - Bits 0..19 of 0x06850 appear LSB-first with `bit_valid` high for 20 cycles.
  - `frame_start` on the first bit, `frame_done` on the last, `frame_cnt`=1.
- Macro off, `in_valid` held high with words 0xAAAAA then 0x55555: second accept coincides with `frame_done`, and `capture` follows on the next cycle (21-cycle period).
- Macro on, `GAP_CYCLES`=2, same stream: `in_ready`=0 for 2 cycles after `frame_done`, then 1. Period is 24 cycles.
- `rst` asserted at `bit_cnt`==7:
  - The next cycle shows IDLE, `in_ready`=1, no `frame_done`, `frame_cnt` unchanged.
  - A new word then completes normally.
- `in_data` toggled every cycle during SHIFT: `p_in` remains at the accepted value and the serial bits match it.
- 256 back-to-back frames: `frame_cnt` reads 0 after the 256th `frame_done`.
